// File: rtl/led_pkg.sv
// Shared geometry and controller state encoding for the double-buffered LED frame store.
package led_pkg;

  localparam int unsigned FB_ROWS    = 64;
  localparam int unsigned FB_COLS    = 64;
  localparam int unsigned HALF_DEPTH = 2048;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CLEAR     = 2'd1,
    SWAP_WAIT = 2'd2
  } fb_state_e;

endpackage

// File: rtl/fb_bank_ram.sv
// Simple dual-port bank: one synchronous write port, one registered read port.
module fb_bank_ram #(
  parameter int unsigned DEPTH = 2048,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/led_frame_buffer.sv
// Double-buffered 64x64 LED frame store: writes/clears go to the back buffer, the display
// reads the front buffer, and the two are exchanged only at a display frame boundary.
module led_frame_buffer
  import led_pkg::*;
#(
  parameter logic [7:0] CLEAR_DEFAULT = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] wrAddr,
  input  logic [7:0]  wrData,
  input  logic        wrEn,
  input  logic        clearReq,
  input  logic [7:0]  clearColor,
  input  logic        clearColorValid,
  input  logic        swapReq,
  output logic        busy,
  output logic        swapped,
  output logic        frontSel,
  input  logic [10:0] pixelAddress0,
  input  logic [10:0] pixelAddress1,
  output logic [7:0]  pixel0,
  output logic [7:0]  pixel1,
  input  logic        displayDone
);

  localparam logic [10:0] LAST_ADDR = 11'(HALF_DEPTH - 1);

  fb_state_e   state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [7:0]  color_q, color_d;
  logic        pend_q, pend_d;
  logic        front_q, front_d;
  logic        swapped_q, swapped_d;
  logic        rd_sel_q;
  logic [7:0]  pixel0_q, pixel1_q;

  logic        wr_top, wr_bot;
  logic [10:0] wr_addr_b;
  logic [7:0]  wr_data_b;
  logic [7:0]  a_top_rd, a_bot_rd, b_top_rd, b_bot_rd;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    color_d   = color_q;
    pend_d    = pend_q;
    front_d   = front_q;
    swapped_d = 1'b0;
    wr_top    = 1'b0;
    wr_bot    = 1'b0;
    wr_addr_b = wrAddr[10:0];
    wr_data_b = wrData;
    unique case (state_q)
      IDLE: begin
        if (clearReq) begin
          state_d = CLEAR;
          cnt_d   = '0;
          color_d = clearColorValid ? clearColor : CLEAR_DEFAULT;
          pend_d  = swapReq;
        end else begin
          wr_top = wrEn & ~wrAddr[11];
          wr_bot = wrEn & wrAddr[11];
          if (swapReq && displayDone) begin
            front_d   = ~front_q;
            swapped_d = 1'b1;
          end else if (swapReq) begin
            state_d = SWAP_WAIT;
          end
        end
      end
      CLEAR: begin
        wr_top    = 1'b1;
        wr_bot    = 1'b1;
        wr_addr_b = cnt_q;
        wr_data_b = color_q;
        cnt_d     = cnt_q + 11'd1;
        pend_d    = pend_q | swapReq;
        if (cnt_q == LAST_ADDR) begin
          state_d = (pend_q | swapReq) ? SWAP_WAIT : IDLE;
          pend_d  = 1'b0;
        end
      end
      SWAP_WAIT: begin
        if (displayDone) begin
          front_d   = ~front_q;
          swapped_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      color_q   <= '0;
      pend_q    <= 1'b0;
      front_q   <= 1'b0;
      swapped_q <= 1'b0;
      rd_sel_q  <= 1'b0;
      pixel0_q  <= '0;
      pixel1_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      color_q   <= color_d;
      pend_q    <= pend_d;
      front_q   <= front_d;
      swapped_q <= swapped_d;
      // Select travels with the address so in-flight reads survive a swap.
      rd_sel_q  <= front_q;
      pixel0_q  <= rd_sel_q ? b_top_rd : a_top_rd;
      pixel1_q  <= rd_sel_q ? b_bot_rd : a_bot_rd;
    end
  end

  assign busy     = (state_q != IDLE);
  assign swapped  = swapped_q;
  assign frontSel = front_q;
  assign pixel0   = pixel0_q;
  assign pixel1   = pixel1_q;

  // Back buffer is A when B is displayed (front_q = 1).
  fb_bank_ram #(.DEPTH(HALF_DEPTH), .WIDTH(8)) u_a_top (
    .clk   (clk),
    .we    (wr_top & front_q),
    .waddr (wr_addr_b),
    .wdata (wr_data_b),
    .raddr (pixelAddress0),
    .rdata (a_top_rd)
  );

  fb_bank_ram #(.DEPTH(HALF_DEPTH), .WIDTH(8)) u_a_bot (
    .clk   (clk),
    .we    (wr_bot & front_q),
    .waddr (wr_addr_b),
    .wdata (wr_data_b),
    .raddr (pixelAddress1),
    .rdata (a_bot_rd)
  );

  fb_bank_ram #(.DEPTH(HALF_DEPTH), .WIDTH(8)) u_b_top (
    .clk   (clk),
    .we    (wr_top & ~front_q),
    .waddr (wr_addr_b),
    .wdata (wr_data_b),
    .raddr (pixelAddress0),
    .rdata (b_top_rd)
  );

  fb_bank_ram #(.DEPTH(HALF_DEPTH), .WIDTH(8)) u_b_bot (
    .clk   (clk),
    .we    (wr_bot & ~front_q),
    .waddr (wr_addr_b),
    .wdata (wr_data_b),
    .raddr (pixelAddress1),
    .rdata (b_bot_rd)
  );

endmodule

// File: tb/tb_led_frame_buffer.sv
// Directed bench for led_frame_buffer: vector table for write/swap/read, hand sequences for
// clear, deferred swap, simultaneous swap and reset during a clear.
module tb_led_frame_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] wrAddr;
  logic [7:0]  wrData;
  logic        wrEn;
  logic        clearReq;
  logic [7:0]  clearColor;
  logic        clearColorValid;
  logic        swapReq;
  logic        busy;
  logic        swapped;
  logic        frontSel;
  logic [10:0] pixelAddress0;
  logic [10:0] pixelAddress1;
  logic [7:0]  pixel0;
  logic [7:0]  pixel1;
  logic        displayDone;

  int total = 0;
  int bad   = 0;

  led_frame_buffer #(.CLEAR_DEFAULT(8'h00)) dut (
    .clk             (clk),
    .rst             (rst),
    .wrAddr          (wrAddr),
    .wrData          (wrData),
    .wrEn            (wrEn),
    .clearReq        (clearReq),
    .clearColor      (clearColor),
    .clearColorValid (clearColorValid),
    .swapReq         (swapReq),
    .busy            (busy),
    .swapped         (swapped),
    .frontSel        (frontSel),
    .pixelAddress0   (pixelAddress0),
    .pixelAddress1   (pixelAddress1),
    .pixel0          (pixel0),
    .pixel1          (pixel1),
    .displayDone     (displayDone)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] wa;
    logic [7:0]  wd;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic rd(input logic [10:0] a0, input logic [10:0] a1,
                    output logic [7:0] p0, output logic [7:0] p1);
    pixelAddress0 = a0;
    pixelAddress1 = a1;
    tick();
    tick();
    p0 = pixel0;
    p1 = pixel1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [7:0] d);
    wrEn   = 1'b1;
    wrAddr = a;
    wrData = d;
    tick();
    wrEn   = 1'b0;
  endtask

  // Clear with illegal side stimulus (write, clear) injected; returns busy-cycle count.
  task automatic run_clear(input logic [7:0] col, input logic valid, input bit with_swap,
                           output int n);
    clearReq        = 1'b1;
    clearColor      = col;
    clearColorValid = valid;
    tick();
    clearReq = 1'b0;
    n = 0;
    while (busy && n < 2048) begin
      swapReq    = with_swap && (n == 10);
      wrEn       = (n == 20);
      wrAddr     = 12'h005;
      wrData     = 8'h99;
      clearReq   = (n == 30);
      if (n == 30) clearColor = 8'h01;
      tick();
      n++;
    end
    swapReq  = 1'b0;
    wrEn     = 1'b0;
    clearReq = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    logic [7:0] p0, p1;
    int n, errs;

    vecs[0] = '{wa: 12'h000, wd: 8'h07};
    vecs[1] = '{wa: 12'h041, wd: 8'h15};
    vecs[2] = '{wa: 12'h800, wd: 8'h2A};
    vecs[3] = '{wa: 12'h7FF, wd: 8'h3C};
    vecs[4] = '{wa: 12'hFFF, wd: 8'h01};
    vecs[5] = '{wa: 12'h7C0, wd: 8'h22};
    vecs[6] = '{wa: 12'h83F, wd: 8'h11};
    vecs[7] = '{wa: 12'h400, wd: 8'h30};

    rst = 1'b0; wrAddr = '0; wrData = '0; wrEn = 1'b0; clearReq = 1'b0;
    clearColor = '0; clearColorValid = 1'b0; swapReq = 1'b0; displayDone = 1'b0;
    pixelAddress0 = '0; pixelAddress1 = '0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_swapped", swapped, 0);
    chk("rst_front", frontSel, 0);
    chk("rst_pixel0", pixel0, 0);
    chk("rst_pixel1", pixel1, 0);
    rst = 1'b1;
    tick();

    // Stray displayDone must not swap.
    displayDone = 1'b1; tick(); displayDone = 1'b0; tick();
    chk("stray_done_front", frontSel, 0);
    chk("stray_done_swapped", swapped, 0);

    for (int i = 0; i < 8; i++) wr(vecs[i].wa, vecs[i].wd);

    // Deferred swap; a write in SWAP_WAIT must be dropped.
    swapReq = 1'b1; tick(); swapReq = 1'b0;
    chk("swapwait_busy", busy, 1);
    wr(12'h041, 8'hFF);
    tick();
    chk("swapwait_front_held", frontSel, 0);
    displayDone = 1'b1; tick(); displayDone = 1'b0;
    chk("swap_front", frontSel, 1);
    chk("swap_pulse", swapped, 1);
    chk("swap_busy", busy, 0);
    tick();
    chk("swap_pulse_end", swapped, 0);

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].wa[11]) begin
        rd(11'h000, vecs[i].wa[10:0], p0, p1);
        chk($sformatf("vec%0d_pixel1", i), p1, vecs[i].wd);
      end else begin
        rd(vecs[i].wa[10:0], 11'h000, p0, p1);
        chk($sformatf("vec%0d_pixel0", i), p0, vecs[i].wd);
      end
    end

    // Same-cycle swap+done in IDLE with a write: write lands in old back buffer (A).
    wrEn = 1'b1; wrAddr = 12'h123; wrData = 8'h5A; swapReq = 1'b1; displayDone = 1'b1;
    tick();
    wrEn = 1'b0; swapReq = 1'b0; displayDone = 1'b0;
    chk("fast_swap_front", frontSel, 0);
    chk("fast_swap_pulse", swapped, 1);
    chk("fast_swap_busy", busy, 0);
    rd(11'h123, 11'h000, p0, p1);
    chk("fast_swap_write", p0, 8'h5A);

    // Reset at cycle 100 of a clear into B.
    wr(12'h0C8, 8'h55);
    clearReq = 1'b1; clearColor = 8'h3F; clearColorValid = 1'b1;
    tick();
    clearReq = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    #2 rst = 1'b0;
    #1;
    chk("midclr_rst_busy", busy, 0);
    chk("midclr_rst_front", frontSel, 0);
    chk("midclr_rst_pixel0", pixel0, 0);
    chk("midclr_rst_pixel1", pixel1, 0);
    tick(); tick();
    rst = 1'b1;
    tick(); tick();
    chk("midclr_idle", busy, 0);
    swapReq = 1'b1; displayDone = 1'b1; tick(); swapReq = 1'b0; displayDone = 1'b0;
    chk("midclr_swap_front", frontSel, 1);
    rd(11'h032, 11'h032, p0, p1);
    chk("midclr_cleared_top", p0, 8'h3F);
    chk("midclr_cleared_bot", p1, 8'h3F);
    rd(11'h0C8, 11'h000, p0, p1);
    chk("midclr_untouched", p0, 8'h55);

    // Full clear of A with swap requested mid-clear.
    run_clear(8'h3F, 1'b1, 1'b1, n);
    chk("clr_cycles", n, 2048);
    chk("clr_to_swapwait", busy, 1);
    swapReq = 1'b1; tick(); swapReq = 1'b0;
    tick(); tick();
    chk("clr_front_held", frontSel, 1);
    chk("clr_no_early_pulse", swapped, 0);
    displayDone = 1'b1; tick(); displayDone = 1'b0;
    chk("clr_swap_front", frontSel, 0);
    chk("clr_swap_pulse", swapped, 1);
    chk("clr_swap_idle", busy, 0);
    tick();
    chk("clr_swap_pulse_once", swapped, 0);

    errs = 0;
    for (int i = 0; i <= 2048; i++) begin
      if (i < 2048) begin
        pixelAddress0 = 11'(i);
        pixelAddress1 = 11'(i);
      end
      tick();
      if (i >= 1) begin
        if (pixel0 !== 8'h3F) errs++;
        if (pixel1 !== 8'h3F) errs++;
      end
    end
    chk("clr_fill_errors", errs, 0);

    // Default-colour clear of B without swap; clearColor must be ignored.
    run_clear(8'h3F, 1'b0, 1'b0, n);
    chk("dflt_cycles", n, 2048);
    chk("dflt_idle", busy, 0);
    chk("dflt_front", frontSel, 0);
    swapReq = 1'b1; tick(); swapReq = 1'b0;
    displayDone = 1'b1; tick(); displayDone = 1'b0;
    chk("dflt_swap_front", frontSel, 1);
    rd(11'h0C8, 11'h7FF, p0, p1);
    chk("dflt_top", p0, 8'h00);
    chk("dflt_bot", p1, 8'h00);
    rd(11'h005, 11'h005, p0, p1);
    chk("dflt_ignored_write", p0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
